// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_if
// Brief    : Operand/result handshake bundle between fetch, alu_pipe, writeback.
// Revision : 1.0
// ============================================================================
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       OPCODE;
  logic [WIDTH-1:0] OP1;
  logic [WIDTH-1:0] OP2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] RESULT;
  logic             CARRY;
  logic             ZERO;
  logic             OVERFLOW;

  // master = upstream producer / downstream consumer side, slave = the ALU
  modport master (
    output in_valid, OPCODE, OP1, OP2, out_ready,
    input  in_ready, out_valid, RESULT, CARRY, ZERO, OVERFLOW
  );

  modport slave (
    input  in_valid, OPCODE, OP1, OP2, out_ready,
    output in_ready, out_valid, RESULT, CARRY, ZERO, OVERFLOW
  );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Registered ALU with flags, valid/ready handshake, iterative MUL
//            and optional unsigned saturation of ADD/SUB.
// Revision : 1.0
// ============================================================================
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter bit SAT_EN = 1'b0
) (
  input wire         clk,
  input wire         rstn,
  alu_pipe_if.slave  bus
);

  localparam int c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [31:0] c_W32 = WIDTH;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_SHL = 3'b101;
  localparam logic [2:0] c_OP_SHR = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  logic                 r_ready_en;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_result;
  logic                 r_carry;
  logic                 r_zero;
  logic                 r_ovf;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_accept;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [31:0]          w_sh_amt;
  logic [WIDTH:0]       w_shl_ext;
  logic [WIDTH:0]       w_shr_ext;
  logic [WIDTH-1:0]     w_res;
  logic                 w_carry;
  logic                 w_ovf;
  logic [2*WIDTH-1:0]   w_acc_nxt;

  // r_ready_en keeps in_ready low until the first edge after reset release
  assign bus.in_ready = r_ready_en && (r_state == ST_IDLE) &&
                        (!r_out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;

  assign w_sum     = {1'b0, bus.OP1} + {1'b0, bus.OP2};
  assign w_diff    = {1'b0, bus.OP1} - {1'b0, bus.OP2};
  assign w_sh_amt  = 32'(bus.OP2) % c_W32;
  // One guard bit on the shift-out side captures the last bit shifted out
  assign w_shl_ext = {1'b0, bus.OP1} << w_sh_amt;
  assign w_shr_ext = {bus.OP1, 1'b0} >> w_sh_amt;

  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (bus.OPCODE)
      c_OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (bus.OP1[WIDTH-1] == bus.OP2[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != bus.OP1[WIDTH-1]);
        if (SAT_EN && w_sum[WIDTH]) w_res = '1;
      end
      c_OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (bus.OP1[WIDTH-1] != bus.OP2[WIDTH-1]) &&
                  (w_diff[WIDTH-1] != bus.OP1[WIDTH-1]);
        if (SAT_EN && w_diff[WIDTH]) w_res = '0;
      end
      c_OP_AND: w_res = bus.OP1 & bus.OP2;
      c_OP_OR:  w_res = bus.OP1 | bus.OP2;
      c_OP_XOR: w_res = bus.OP1 ^ bus.OP2;
      c_OP_SHL: begin
        w_res   = w_shl_ext[WIDTH-1:0];
        w_carry = w_shl_ext[WIDTH];
      end
      c_OP_SHR: begin
        w_res   = w_shr_ext[WIDTH:1];
        w_carry = w_shr_ext[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_ready_en  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      r_ready_en <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (bus.OPCODE == c_OP_MUL) begin
              r_state     <= ST_BUSY;
              r_out_valid <= 1'b0;
              r_mcand     <= {{WIDTH{1'b0}}, bus.OP1};
              r_mplier    <= bus.OP2;
              r_acc       <= '0;
              r_cnt       <= '0;
            end else begin
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_carry     <= w_carry;
              r_zero      <= (w_res == '0);
              r_ovf       <= w_ovf;
            end
          end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b1;
            r_result    <= w_acc_nxt[WIDTH-1:0];
            r_carry     <= 1'b0;
            r_zero      <= (w_acc_nxt[WIDTH-1:0] == '0);
            r_ovf       <= (w_acc_nxt[2*WIDTH-1:WIDTH] != '0);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.RESULT    = r_result;
  assign bus.CARRY     = r_carry;
  assign bus.ZERO      = r_zero;
  assign bus.OVERFLOW  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Directed self-checking bench; wrap and saturating instances share
//            one stimulus stream.
// Revision : 1.0
// ============================================================================
module tb_alu_pipe;

  localparam int WIDTH = 8;

  logic             clk       = 1'b0;
  logic             rstn      = 1'b0;
  logic             in_valid  = 1'b0;
  logic [2:0]       opcode    = 3'b000;
  logic [WIDTH-1:0] op1       = '0;
  logic [WIDTH-1:0] op2       = '0;
  logic             out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(WIDTH)) bus0 ();
  alu_pipe_if #(.WIDTH(WIDTH)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.OPCODE    = opcode;
  assign bus0.OP1       = op1;
  assign bus0.OP2       = op2;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.OPCODE    = opcode;
  assign bus1.OP1       = op1;
  assign bus1.OP2       = op2;
  assign bus1.out_ready = out_ready;

  alu_pipe #(.WIDTH(WIDTH), .SAT_EN(1'b0)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus0)
  );

  alu_pipe #(.WIDTH(WIDTH), .SAT_EN(1'b1)) dut_sat (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready=1, wait for the result, check both instances.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] e_res, input logic [7:0] e_res_sat,
                        input logic e_c, input logic e_z, input logic e_z_sat,
                        input logic e_o, input int e_lat);
    int lat;
    int busy;
    check_eq({tag, ":in_ready"}, 32'(bus0.in_ready), 32'd1);
    opcode    = op;
    op1       = a;
    op2       = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode   = 3'b000;
    op1      = 8'hFF;
    op2      = 8'hFF;
    lat  = 1;
    busy = 0;
    while (!bus0.out_valid && lat < 40) begin
      if (!bus0.in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, ":latency"},  32'(lat),           32'(e_lat));
    check_eq({tag, ":busy"},     32'(busy),          32'(e_lat - 1));
    check_eq({tag, ":result"},   32'(bus0.RESULT),   32'(e_res));
    check_eq({tag, ":carry"},    32'(bus0.CARRY),    32'(e_c));
    check_eq({tag, ":zero"},     32'(bus0.ZERO),     32'(e_z));
    check_eq({tag, ":ovf"},      32'(bus0.OVERFLOW), 32'(e_o));
    check_eq({tag, ":sat_vld"},  32'(bus1.out_valid), 32'd1);
    check_eq({tag, ":sat_res"},  32'(bus1.RESULT),   32'(e_res_sat));
    check_eq({tag, ":sat_zero"}, 32'(bus1.ZERO),     32'(e_z_sat));
    check_eq({tag, ":sat_carry"}, 32'(bus1.CARRY),   32'(e_c));
  endtask

  logic [7:0] xa [4] = '{8'hA5, 8'h12, 8'hFF, 8'h3C};
  logic [7:0] xb [4] = '{8'hFF, 8'h34, 8'h01, 8'hC3};
  logic [7:0] xr [4] = '{8'h5A, 8'h26, 8'hFE, 8'hFF};

  initial begin
    int seen;
    // Reset state
    #2;
    check_eq("rst:out_valid", 32'(bus0.out_valid), 32'd0);
    check_eq("rst:result",    32'(bus0.RESULT),    32'd0);
    check_eq("rst:carry",     32'(bus0.CARRY),     32'd0);
    check_eq("rst:zero",      32'(bus0.ZERO),      32'd0);
    check_eq("rst:ovf",       32'(bus0.OVERFLOW),  32'd0);
    check_eq("rst:in_ready",  32'(bus0.in_ready),  32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check_eq("rel:in_ready", 32'(bus0.in_ready), 32'd1);

    //      tag           op      a      b      res    sat    c     z     zs    o    lat
    run_op("add_ff_01",  3'd0, 8'hFF, 8'h01, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    run_op("sub_80_01",  3'd1, 8'h80, 8'h01, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    run_op("sub_01_02",  3'd1, 8'h01, 8'h02, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    run_op("add_7f_01",  3'd0, 8'h7F, 8'h01, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    run_op("or_0f_30",   3'd3, 8'h0F, 8'h30, 8'h3F, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_op("xor_5a_5a",  3'd4, 8'h5A, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    run_op("shr_81_1",   3'd6, 8'h81, 8'h01, 8'h40, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    run_op("shl_03_7",   3'd5, 8'h03, 8'h07, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    run_op("shr_81_8",   3'd6, 8'h81, 8'h08, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_op("mul_10_20",  3'd7, 8'h10, 8'h20, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 9);
    run_op("mul_0f_0f",  3'd7, 8'h0F, 8'h0F, 8'hE1, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    run_op("mul_ff_ff",  3'd7, 8'hFF, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 9);
    run_op("sat_add",    3'd0, 8'hF0, 8'h20, 8'h10, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    run_op("sat_sub",    3'd1, 8'h10, 8'h20, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    run_op("sat_shl_9",  3'd5, 8'h81, 8'h09, 8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1);

    // Drain, then backpressure on an AND result
    @(posedge clk); #1;
    check_eq("drain:out_valid", 32'(bus0.out_valid), 32'd0);
    opcode = 3'd2; op1 = 8'hF0; op2 = 8'h3C; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    opcode = 3'd4; op1 = xa[0]; op2 = xb[0];
    for (int i = 0; i < 5; i++) begin
      check_eq("bp:out_valid", 32'(bus0.out_valid), 32'd1);
      check_eq("bp:result",    32'(bus0.RESULT),    32'h30);
      check_eq("bp:in_ready",  32'(bus0.in_ready),  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op1 = xa[i];
      op2 = xb[i];
      @(posedge clk); #1;
      check_eq("stream:out_valid", 32'(bus0.out_valid), 32'd1);
      check_eq("stream:result",    32'(bus0.RESULT),    32'(xr[i]));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("stream:done", 32'(bus0.out_valid), 32'd0);

    // Reset in the 4th cycle of a MUL
    opcode = 3'd7; op1 = 8'h0F; op2 = 8'h0F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_eq("mulrst:busy", 32'(bus0.in_ready), 32'd0);
    rstn = 1'b0;
    #1;
    check_eq("mulrst:out_valid", 32'(bus0.out_valid), 32'd0);
    check_eq("mulrst:result",    32'(bus0.RESULT),    32'd0);
    check_eq("mulrst:zero",      32'(bus0.ZERO),      32'd0);
    check_eq("mulrst:in_ready",  32'(bus0.in_ready),  32'd0);
    check_eq("mulrst:sat_vld",   32'(bus1.out_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check_eq("mulrst:in_ready_rel", 32'(bus0.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus0.out_valid || bus1.out_valid) seen++;
      @(posedge clk); #1;
    end
    check_eq("mulrst:no_stale", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
